// File: rtl/cached_main_memory.sv
// Word-addressed instruction/data memory with a direct-mapped, write-through,
// no-write-allocate cache in front of a multi-cycle backing store.
module cached_main_memory #(
   parameter int unsigned DATA_W      = 13,
   parameter int unsigned ADDR_W      = 13,
   parameter int unsigned MEM_DEPTH   = 256,
   parameter int unsigned LINES       = 8,
   parameter int unsigned MEM_LATENCY = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] dataIn,
   output logic [DATA_W-1:0] dataOut,
   input  logic              write,
   input  logic              read,
   input  logic              instruction,
   output logic              Done,
   output logic              hit,
   output logic              busy
);

   localparam int unsigned IDX_W  = $clog2(LINES);
   localparam int unsigned TAG_W  = ADDR_W - IDX_W + 1;
   localparam int unsigned MIDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int unsigned CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, MEM_WAIT, RESP} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   din_q, din_d;
   logic                instr_q, instr_d;
   logic                wr_q, wr_d;
   logic [DATA_W-1:0]   dout_q, dout_d;
   logic                done_q, done_d;
   logic                hit_q, hit_d;
   logic                busy_q, busy_d;

   logic                valid_q [LINES];
   logic [TAG_W-1:0]    tag_q   [LINES];
   logic [DATA_W-1:0]   line_q  [LINES];
   logic [DATA_W-1:0]   ibank_q [MEM_DEPTH] = '{default: '0};
   logic [DATA_W-1:0]   dbank_q [MEM_DEPTH] = '{default: '0};

   logic [IDX_W-1:0]    in_idx_c, q_idx_c;
   logic [TAG_W-1:0]    in_tag_c, q_tag_c;
   logic                in_hit_c, q_hit_c;
   logic [MIDX_W-1:0]   bank_idx_c;
   logic [DATA_W-1:0]   bank_rd_c;
   logic                mem_we_c, fill_c, upd_c;

   // Lookup on live inputs for read-hit acceptance, on latched request otherwise
   assign in_idx_c   = address[IDX_W-1:0];
   assign in_tag_c   = {instruction, address[ADDR_W-1:IDX_W]};
   assign in_hit_c   = valid_q[in_idx_c] && (tag_q[in_idx_c] == in_tag_c);
   assign q_idx_c    = addr_q[IDX_W-1:0];
   assign q_tag_c    = {instr_q, addr_q[ADDR_W-1:IDX_W]};
   assign q_hit_c    = valid_q[q_idx_c] && (tag_q[q_idx_c] == q_tag_c);
   assign bank_idx_c = MIDX_W'(32'(addr_q) % MEM_DEPTH);
   assign bank_rd_c  = instr_q ? ibank_q[bank_idx_c] : dbank_q[bank_idx_c];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      din_d    = din_q;
      instr_d  = instr_q;
      wr_d     = wr_q;
      dout_d   = dout_q;
      done_d   = 1'b0;
      hit_d    = hit_q;
      mem_we_c = 1'b0;
      fill_c   = 1'b0;
      upd_c    = 1'b0;
      case (state_q)
         IDLE: begin
            if (write || read) begin
               addr_d  = address;
               din_d   = dataIn;
               instr_d = instruction;
               wr_d    = write;
               if (!write && in_hit_c) begin
                  state_d = RESP;
                  dout_d  = line_q[in_idx_c];
                  hit_d   = 1'b1;
                  done_d  = 1'b1;
               end else begin
                  state_d = MEM_WAIT;
                  cnt_d   = CNT_W'(MEM_LATENCY - 1);
               end
            end
         end
         MEM_WAIT: begin
            if (cnt_q == '0) begin
               state_d = RESP;
               done_d  = 1'b1;
               if (wr_q) begin
                  mem_we_c = 1'b1;
                  upd_c    = q_hit_c;
                  hit_d    = q_hit_c;
               end else begin
                  fill_c = 1'b1;
                  dout_d = bank_rd_c;
                  hit_d  = 1'b0;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dout_q  <= '0;
         done_q  <= 1'b0;
         hit_q   <= 1'b0;
         busy_q  <= 1'b0;
         for (int i = 0; i < int'(LINES); i++) valid_q[i] <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
         hit_q   <= hit_d;
         busy_q  <= busy_d;
         if (fill_c) valid_q[q_idx_c] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      addr_q  <= addr_d;
      din_q   <= din_d;
      instr_q <= instr_d;
      wr_q    <= wr_d;
   end

   // Storage updates are suppressed on a reset edge so an aborted write is dropped
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (fill_c) begin
            tag_q[q_idx_c]  <= q_tag_c;
            line_q[q_idx_c] <= bank_rd_c;
         end
         if (upd_c) line_q[q_idx_c] <= din_q;
         if (mem_we_c) begin
            if (instr_q) ibank_q[bank_idx_c] <= din_q;
            else         dbank_q[bank_idx_c] <= din_q;
         end
      end
   end

   assign dataOut = dout_q;
   assign Done    = done_q;
   assign hit     = hit_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_cached_main_memory.sv
// Self-checking bench: directed scenarios plus random traffic against a
// transaction-level memory/cache reference model.
module tb_cached_main_memory;
   localparam int unsigned DATA_W = 13, ADDR_W = 13, MEM_DEPTH = 256, LINES = 8, MEM_LATENCY = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [ADDR_W-1:0] address = '0;
   logic [DATA_W-1:0] dataIn = '0;
   logic [DATA_W-1:0] dataOut;
   logic write = 1'b0, read = 1'b0, instruction = 1'b0;
   logic Done, hit, busy;

   always #5 clk = ~clk;

   cached_main_memory #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH),
                        .LINES(LINES), .MEM_LATENCY(MEM_LATENCY)) dut (
      .clk(clk), .reset(reset), .address(address), .dataIn(dataIn), .dataOut(dataOut),
      .write(write), .read(read), .instruction(instruction), .Done(Done), .hit(hit), .busy(busy));

   int n_checks = 0, n_errors = 0;
   int mbank [2][MEM_DEPTH];
   int mkey  [LINES];
   int mdata [LINES];
   bit mvalid[LINES];
   int mdout = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_idle();
      int guard = 0;
      while (busy && guard < 50) begin @(negedge clk); guard++; end
      if (busy) chk("idle_timeout", 1, 0);
   endtask

   // Model and execute one request; checks latency, Done, hit and dataOut
   task automatic do_op(input bit wr, input bit rd, input bit ins, input int addr, input int din,
                        input string tag);
      int line, key, bidx, dm, exp_hit, exp_lat, lat;
      wait_idle();
      line = addr % LINES;
      key  = ins * (1 << ADDR_W) + addr;
      bidx = addr % MEM_DEPTH;
      dm   = din & ((1 << DATA_W) - 1);
      exp_hit = (mvalid[line] && mkey[line] == key) ? 1 : 0;
      if (wr) begin
         mbank[ins][bidx] = dm;
         if (exp_hit != 0) mdata[line] = dm;
         exp_lat = 1 + MEM_LATENCY;
      end else if (exp_hit != 0) begin
         exp_lat = 1;
         mdout   = mdata[line];
      end else begin
         exp_lat = 1 + MEM_LATENCY;
         mdout   = mbank[ins][bidx];
         mvalid[line] = 1'b1;
         mkey[line]   = key;
         mdata[line]  = mdout;
      end
      write = wr; read = rd; instruction = ins;
      address = ADDR_W'(addr); dataIn = DATA_W'(din);
      @(negedge clk);
      lat = 1;
      write = 1'b0; read = 1'b0;
      address = ADDR_W'($urandom); dataIn = DATA_W'($urandom); instruction = 1'($urandom);
      chk({tag, ".busy"}, busy, 1);
      while (!Done && lat < 20) begin @(negedge clk); lat++; end
      chk({tag, ".done"}, Done, 1);
      chk({tag, ".lat"}, lat, exp_lat);
      chk({tag, ".hit"}, hit, exp_hit);
      chk({tag, ".dout"}, dataOut, mdout);
   endtask

   initial begin
      bit seen_done;
      int a;
      bit w, r;
      reset = 1'b1;
      @(negedge clk); @(negedge clk);
      chk("rst.dout", dataOut, 0);
      chk("rst.done", Done, 0);
      chk("rst.hit", hit, 0);
      chk("rst.busy", busy, 0);
      reset = 1'b0;
      @(negedge clk);

      do_op(0, 1, 0, 0, 0, "rd0_miss");
      do_op(0, 1, 0, 0, 0, "rd0_hit");
      do_op(1, 0, 0, 0, 16'hF0F0, "wr0");
      do_op(0, 1, 0, 0, 0, "rd0_after_wr");
      do_op(0, 1, 0, 8, 0, "rd8_alias");
      do_op(0, 1, 0, 0, 0, "rd0_evicted");
      do_op(0, 1, 1, 0, 0, "rdi0");
      do_op(1, 0, 1, 0, 13'h0ABC, "wri0");
      do_op(0, 1, 0, 0, 0, "rd0_sep");
      do_op(1, 0, 0, 263, 13'h0123, "wr_wrap");
      do_op(0, 1, 0, 7, 0, "rd_wrap");

      // Reset two cycles into a write: request and bank update must vanish
      wait_idle();
      write = 1'b1; address = ADDR_W'(3); dataIn = 13'h0AAA; instruction = 1'b0;
      @(negedge clk);
      write = 1'b0;
      seen_done = Done;
      @(negedge clk);
      seen_done = seen_done | Done;
      reset = 1'b1;
      @(negedge clk);
      chk("abort.busy", busy, 0);
      chk("abort.done", int'(seen_done | Done), 0);
      reset = 1'b0;
      for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
      mdout = 0;
      seen_done = 1'b0;
      for (int i = 0; i < 6; i++) begin @(negedge clk); seen_done = seen_done | Done; end
      chk("abort.nodone", int'(seen_done), 0);
      do_op(0, 1, 0, 3, 0, "rd3_after_abort");

      do_op(1, 1, 0, 5, 13'h0055, "rdwr5");
      do_op(0, 1, 0, 5, 0, "rd5");

      // Held read on a hit completes every other cycle
      wait_idle();
      read = 1'b1; address = ADDR_W'(5); instruction = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         chk($sformatf("held.done%0d", i), Done, i % 2);
         if (Done) begin
            chk($sformatf("held.hit%0d", i), hit, 1);
            chk($sformatf("held.dout%0d", i), dataOut, 13'h0055);
         end
      end
      read = 1'b0;

      for (int n = 0; n < 80; n++) begin
         a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8191)) : int'($urandom_range(0, 23));
         w = ($urandom_range(0, 2) == 0);
         r = w ? 1'($urandom) : 1'b1;
         do_op(w, r, 1'($urandom), a, int'($urandom_range(0, 65535)), $sformatf("rnd%0d", n));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
